// File: rtl/vw_issue_ctrl.sv
// vw_issue_ctrl: sequences one variable-width vector instruction over the PE array, with an optional widening-reduction tree phase
module vw_issue_ctrl #(
  parameter int NUM_PE = 4,
  parameter int VL_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [VL_W-1:0]   req_vl_i,
  input  logic [1:0]        req_vsew_i,
  input  logic [1:0]        req_widening_i,
  input  logic              req_reduce_i,
  output logic              dp_valid_o,
  input  logic              dp_ready_i,
  output logic [1:0]        dp_vsew_o,
  output logic [1:0]        dp_widening_o,
  output logic              dp_wide_b_o,
  output logic [NUM_PE-1:0] dp_pe_en_o,
  output logic [VL_W-1:0]   dp_elem_idx_o,
  output logic              dp_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              illegal_o
);
  localparam int LG = $clog2(NUM_PE);
  typedef enum logic [1:0] {IDLE, RUN, RED, DONE} state_t;
  state_t            state_q, state_d;
  logic [VL_W-1:0]   vl_q, vl_d, idx_q, idx_d, rem;
  logic [1:0]        vsew_q, vsew_d, wid_q, wid_d;
  logic              red_q, red_d, ill_q, ill_d;
  logic [LG-1:0]     k_q, k_d;
  logic              legal, last_grp, last_tree, run, tree;
  logic [NUM_PE-1:0] run_en, red_en;
  assign legal = !(req_vsew_i == 2'd3 || req_widening_i == 2'd3 ||
                   (req_widening_i == 2'd1 && req_vsew_i == 2'd2) ||
                   (req_widening_i == 2'd2 && req_vsew_i != 2'd0) ||
                   (req_reduce_i && req_widening_i != 2'd1));
  assign rem       = vl_q - idx_q;
  assign last_grp  = {1'b0, rem} <= (VL_W+1)'(NUM_PE);
  assign last_tree = k_q == LG'(LG - 1);
  assign run       = state_q == RUN;
  assign tree      = state_q == RED;
  for (genvar g = 0; g < NUM_PE; g++) begin : g_en
    assign run_en[g] = {1'b0, rem} > (VL_W+1)'(g);
    assign red_en[g] = 32'(g) < (NUM_PE >> (32'(k_q) + 32'd1));
  end
  assign req_ready_o   = state_q == IDLE;
  assign busy_o        = state_q != IDLE;
  assign done_o        = state_q == DONE;
  assign illegal_o     = done_o && ill_q;
  assign dp_valid_o    = run || tree;
  assign dp_vsew_o     = dp_valid_o ? vsew_q : 2'd0;
  assign dp_widening_o = dp_valid_o ? wid_q : 2'd0;
  assign dp_wide_b_o   = run ? red_q : tree;
  assign dp_pe_en_o    = run ? run_en : tree ? red_en : '0;
  assign dp_elem_idx_o = run ? idx_q : '0;
  assign dp_last_o     = (run && last_grp && !red_q) || (tree && last_tree);
  // State and captured-request registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      vl_q    <= '0;
      idx_q   <= '0;
      vsew_q  <= '0;
      wid_q   <= '0;
      red_q   <= 1'b0;
      ill_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      vl_q    <= vl_d;
      idx_q   <= idx_d;
      vsew_q  <= vsew_d;
      wid_q   <= wid_d;
      red_q   <= red_d;
      ill_q   <= ill_d;
      k_q     <= k_d;
    end
  end
  // Next state: accept/legality check, group stepping, tree stepping
  always_comb begin
    state_d = state_q;
    vl_d    = vl_q;
    idx_d   = idx_q;
    vsew_d  = vsew_q;
    wid_d   = wid_q;
    red_d   = red_q;
    ill_d   = ill_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        vl_d    = req_vl_i;
        vsew_d  = req_vsew_i;
        wid_d   = req_widening_i;
        red_d   = req_reduce_i;
        ill_d   = !legal;
        idx_d   = '0;
        k_d     = '0;
        state_d = (legal && req_vl_i != '0) ? RUN : DONE;
      end
      RUN: if (dp_ready_i) begin
        idx_d   = last_grp ? idx_q : idx_q + VL_W'(NUM_PE);
        state_d = !last_grp ? RUN : red_q ? RED : DONE;
      end
      RED: if (dp_ready_i) begin
        k_d     = last_tree ? k_q : k_q + LG'(1);
        state_d = last_tree ? DONE : RED;
      end
      default: begin
        state_d = IDLE;
        ill_d   = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_vw_issue_ctrl.sv
// tb_vw_issue_ctrl: directed-vector self-checking bench for vw_issue_ctrl (NUM_PE=4, VL_W=8)
module tb_vw_issue_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [7:0] req_vl_i;
  logic [1:0] req_vsew_i;
  logic [1:0] req_widening_i;
  logic       req_reduce_i;
  logic       dp_valid_o;
  logic       dp_ready_i;
  logic [1:0] dp_vsew_o;
  logic [1:0] dp_widening_o;
  logic       dp_wide_b_o;
  logic [3:0] dp_pe_en_o;
  logic [7:0] dp_elem_idx_o;
  logic       dp_last_o;
  logic       busy_o;
  logic       done_o;
  logic       illegal_o;
  int         n_vec = 0;
  int         n_err = 0;
  int         hs = 0;
  int         hs0;
  vw_issue_ctrl #(.NUM_PE(4), .VL_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_vl_i(req_vl_i), .req_vsew_i(req_vsew_i),
    .req_widening_i(req_widening_i), .req_reduce_i(req_reduce_i),
    .dp_valid_o(dp_valid_o), .dp_ready_i(dp_ready_i),
    .dp_vsew_o(dp_vsew_o), .dp_widening_o(dp_widening_o),
    .dp_wide_b_o(dp_wide_b_o), .dp_pe_en_o(dp_pe_en_o),
    .dp_elem_idx_o(dp_elem_idx_o), .dp_last_o(dp_last_o),
    .busy_o(busy_o), .done_o(done_o), .illegal_o(illegal_o)
  );
  always #5 clk_i = ~clk_i;
  // Count datapath handshakes
  always @(posedge clk_i) if (rst_ni && dp_valid_o && dp_ready_i) hs <= hs + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input string t, input logic v, input logic [3:0] en, input logic [7:0] idx,
                      input logic last, input logic wb, input logic [1:0] sew, input logic [1:0] wid);
    chk({t, ".valid"}, 32'(dp_valid_o), 32'(v));
    chk({t, ".en"}, 32'(dp_pe_en_o), 32'(en));
    chk({t, ".idx"}, 32'(dp_elem_idx_o), 32'(idx));
    chk({t, ".last"}, 32'(dp_last_o), 32'(last));
    chk({t, ".wide_b"}, 32'(dp_wide_b_o), 32'(wb));
    chk({t, ".vsew"}, 32'(dp_vsew_o), 32'(sew));
    chk({t, ".wid"}, 32'(dp_widening_o), 32'(wid));
  endtask
  task automatic fin(input string t, input logic ill);
    beat(t, 1'b0, 4'h0, 8'h0, 1'b0, 1'b0, 2'd0, 2'd0);
    chk({t, ".done"}, 32'(done_o), 32'd1);
    chk({t, ".illegal"}, 32'(illegal_o), 32'(ill));
    chk({t, ".busy"}, 32'(busy_o), 32'd1);
    @(negedge clk_i);
    chk({t, ".done_drop"}, 32'(done_o), 32'd0);
    chk({t, ".idle"}, 32'(busy_o), 32'd0);
    chk({t, ".ready"}, 32'(req_ready_o), 32'd1);
  endtask
  task automatic issue(input string t, input logic [7:0] vl, input logic [1:0] sew,
                       input logic [1:0] wid, input logic red);
    req_valid_i    = 1'b1;
    req_vl_i       = vl;
    req_vsew_i     = sew;
    req_widening_i = wid;
    req_reduce_i   = red;
    chk({t, ".req_ready"}, 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask
  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_vl_i = '0; req_vsew_i = '0;
    req_widening_i = '0; req_reduce_i = 1'b0; dp_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    beat("rst", 1'b0, 4'h0, 8'h0, 1'b0, 1'b0, 2'd0, 2'd0);
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.done", 32'(done_o), 32'd0);
    chk("rst.illegal", 32'(illegal_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst.ready", 32'(req_ready_o), 32'd1);
    issue("vl10", 8'd10, 2'd0, 2'd0, 1'b0);
    beat("vl10.b0", 1'b1, 4'hF, 8'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    @(negedge clk_i);
    beat("vl10.b1", 1'b1, 4'hF, 8'd4, 1'b0, 1'b0, 2'd0, 2'd0);
    @(negedge clk_i);
    beat("vl10.b2", 1'b1, 4'h3, 8'd8, 1'b1, 1'b0, 2'd0, 2'd0);
    @(negedge clk_i);
    fin("vl10.done", 1'b0);
    issue("wred", 8'd6, 2'd0, 2'd1, 1'b1);
    beat("wred.r0", 1'b1, 4'hF, 8'd0, 1'b0, 1'b1, 2'd0, 2'd1);
    @(negedge clk_i);
    beat("wred.r1", 1'b1, 4'h3, 8'd4, 1'b0, 1'b1, 2'd0, 2'd1);
    @(negedge clk_i);
    beat("wred.t0", 1'b1, 4'h3, 8'd0, 1'b0, 1'b1, 2'd0, 2'd1);
    @(negedge clk_i);
    beat("wred.t1", 1'b1, 4'h1, 8'd0, 1'b1, 1'b1, 2'd0, 2'd1);
    @(negedge clk_i);
    fin("wred.done", 1'b0);
    issue("ill_s1w2", 8'd8, 2'd1, 2'd2, 1'b0);
    fin("ill_s1w2", 1'b1);
    issue("ill_s2w1", 8'd8, 2'd2, 2'd1, 1'b0);
    fin("ill_s2w1", 1'b1);
    issue("ill_r1w0", 8'd8, 2'd0, 2'd0, 1'b1);
    fin("ill_r1w0", 1'b1);
    issue("vl0", 8'd0, 2'd1, 2'd0, 1'b0);
    fin("vl0", 1'b0);
    hs0 = hs;
    issue("stall", 8'd8, 2'd2, 2'd0, 1'b0);
    beat("stall.b0", 1'b1, 4'hF, 8'd0, 1'b0, 1'b0, 2'd2, 2'd0);
    @(negedge clk_i);
    dp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat("stall.hold", 1'b1, 4'hF, 8'd4, 1'b1, 1'b0, 2'd2, 2'd0);
      @(negedge clk_i);
    end
    dp_ready_i = 1'b1;
    beat("stall.go", 1'b1, 4'hF, 8'd4, 1'b1, 1'b0, 2'd2, 2'd0);
    @(negedge clk_i);
    chk("stall.hs", 32'(hs - hs0), 32'd2);
    fin("stall.done", 1'b0);
    issue("abort", 8'd16, 2'd0, 2'd0, 1'b0);
    @(negedge clk_i);
    beat("abort.b2", 1'b1, 4'hF, 8'd4, 1'b0, 1'b0, 2'd0, 2'd0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    beat("abort.rst", 1'b0, 4'h0, 8'h0, 1'b0, 1'b0, 2'd0, 2'd0);
    chk("abort.done", 32'(done_o), 32'd0);
    chk("abort.busy", 32'(busy_o), 32'd0);
    chk("abort.illegal", 32'(illegal_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    issue("post", 8'd5, 2'd1, 2'd0, 1'b0);
    beat("post.b0", 1'b1, 4'hF, 8'd0, 1'b0, 1'b0, 2'd1, 2'd0);
    @(negedge clk_i);
    beat("post.b1", 1'b1, 4'h1, 8'd4, 1'b1, 1'b0, 2'd1, 2'd0);
    @(negedge clk_i);
    fin("post.done", 1'b0);
    issue("vl255", 8'd255, 2'd0, 2'd0, 1'b0);
    beat("vl255.b0", 1'b1, 4'hF, 8'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    repeat (63) @(negedge clk_i);
    beat("vl255.blast", 1'b1, 4'h7, 8'd252, 1'b1, 1'b0, 2'd0, 2'd0);
    @(negedge clk_i);
    fin("vl255.done", 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
